// File: rtl/lamp_sequencer.sv
// lamp_sequencer
//   Turns the traffic controller's one-bit direction grant into the six
//   physical lamp drives. Every change of direction runs the committed
//   sequence: minimum green, timed yellow, timed all-red, opposite green.
//   At most one direction ever shows green or yellow.
//
// Ports
//   clock     rising-edge clock
//   reset     asynchronous, active-high reset
//   NSLite    controller grants north-south
//   EWLite    controller grants east-west
//   NSGreen / NSYellow / NSRed   north-south lamps
//   EWGreen / EWYellow / EWRed   east-west lamps
//   fault     registered: the grant pair sampled last edge was not one-hot
//   busy      high in any yellow or all-red state (and in FLASH)
//
// Optional feature (macro LAMP_FAULT_FLASH_EN)
//   Both grants high on two consecutive edges sends the block to a sticky
//   FLASH state where both reds blink every YELLOW_CYCLES cycles.
//   With the macro undefined an illegal grant only raises fault.

module lamp_sequencer #(
  parameter int MIN_GREEN_CYCLES = 4,
  parameter int YELLOW_CYCLES    = 3,
  parameter int ALLRED_CYCLES    = 2,
  parameter int CNT_W            = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic NSLite,
  input  logic EWLite,
  output logic NSGreen,
  output logic NSYellow,
  output logic NSRed,
  output logic EWGreen,
  output logic EWYellow,
  output logic EWRed,
  output logic fault,
  output logic busy
);

`ifdef LAMP_FAULT_FLASH_EN
  typedef enum logic [2:0] {
    ALLRED_TO_NS, NS_GREEN, NS_YELLOW, ALLRED_TO_EW, EW_GREEN, EW_YELLOW, FLASH
  } state_t;
`else
  typedef enum logic [2:0] {
    ALLRED_TO_NS, NS_GREEN, NS_YELLOW, ALLRED_TO_EW, EW_GREEN, EW_YELLOW
  } state_t;
`endif

  // Terminal timer values: a phase of N cycles ends on the edge where timer==N-1.
  localparam logic [CNT_W-1:0] greenLast  = CNT_W'(MIN_GREEN_CYCLES - 1);
  localparam logic [CNT_W-1:0] yellowLast = CNT_W'(YELLOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] allRedLast = CNT_W'(ALLRED_CYCLES - 1);
  localparam logic [CNT_W-1:0] timerMax   = {CNT_W{1'b1}};

  state_t           state;
  state_t           stateNext;
  logic [CNT_W-1:0] timer;

  logic grantNs;
  logic grantEw;
  logic grantInvalid;

  assign grantNs      = NSLite & ~EWLite;
  assign grantEw      = EWLite & ~NSLite;
  assign grantInvalid = ~(NSLite ^ EWLite);

`ifdef LAMP_FAULT_FLASH_EN
  logic bothHigh;
  logic bothHighPrev;
  logic flashRed;

  assign bothHigh = NSLite & EWLite;

  // Remembers last edge's both-high sample and runs the red blink in FLASH.
  // flashRed sits at 1 outside FLASH so the blink always starts lit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bothHighPrev <= 1'b0;
      flashRed     <= 1'b1;
    end else begin
      bothHighPrev <= bothHigh;
      if (state != FLASH) begin
        flashRed <= 1'b1;
      end else if (timer == yellowLast) begin
        flashRed <= ~flashRed;
      end
    end
  end
`endif

  // State register, phase timer and fault flag. The timer restarts on every
  // state change and otherwise saturates; in FLASH it wraps per blink period.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ALLRED_TO_NS;
      timer <= '0;
      fault <= 1'b0;
    end else begin
      state <= stateNext;
      fault <= grantInvalid;
      if (stateNext != state) begin
        timer <= '0;
`ifdef LAMP_FAULT_FLASH_EN
      end else if (state == FLASH && timer == yellowLast) begin
        timer <= '0;
`endif
      end else if (timer != timerMax) begin
        timer <= timer + 1'b1;
      end
    end
  end

  // Next-state logic. A green only yields to a clean opposite grant sampled
  // on an edge where the minimum has been met; yellow and all-red are
  // committed and ignore the grant entirely.
  always_comb begin
    stateNext = state;
    case (state)
      ALLRED_TO_NS: if (timer == allRedLast) stateNext = NS_GREEN;
      NS_GREEN:     if (grantEw && timer >= greenLast) stateNext = NS_YELLOW;
      NS_YELLOW:    if (timer == yellowLast) stateNext = ALLRED_TO_EW;
      ALLRED_TO_EW: if (timer == allRedLast) stateNext = EW_GREEN;
      EW_GREEN:     if (grantNs && timer >= greenLast) stateNext = EW_YELLOW;
      EW_YELLOW:    if (timer == yellowLast) stateNext = ALLRED_TO_NS;
`ifdef LAMP_FAULT_FLASH_EN
      FLASH:        stateNext = FLASH;
`endif
      default:      stateNext = ALLRED_TO_NS;
    endcase
`ifdef LAMP_FAULT_FLASH_EN
    if (bothHigh && bothHighPrev) stateNext = FLASH;
`endif
  end

  // Moore lamp decode: one lamp per direction, the idle direction shows red.
  always_comb begin
    NSGreen  = 1'b0;
    NSYellow = 1'b0;
    NSRed    = 1'b1;
    EWGreen  = 1'b0;
    EWYellow = 1'b0;
    EWRed    = 1'b1;
    busy     = 1'b1;
    case (state)
      NS_GREEN: begin
        NSGreen = 1'b1;
        NSRed   = 1'b0;
        busy    = 1'b0;
      end
      NS_YELLOW: begin
        NSYellow = 1'b1;
        NSRed    = 1'b0;
      end
      EW_GREEN: begin
        EWGreen = 1'b1;
        EWRed   = 1'b0;
        busy    = 1'b0;
      end
      EW_YELLOW: begin
        EWYellow = 1'b1;
        EWRed    = 1'b0;
      end
`ifdef LAMP_FAULT_FLASH_EN
      FLASH: begin
        NSRed = flashRed;
        EWRed = flashRed;
      end
`endif
      default: begin
        NSRed = 1'b1;
        EWRed = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_lamp_sequencer.sv
// tb_lamp_sequencer
//   Self-checking bench for lamp_sequencer: a table of hand-derived vectors,
//   directed corner sequences (fault pulse, reset mid-yellow, optional FLASH)
//   and a long random run compared against a phase-level reference model.

module tb_lamp_sequencer;

  localparam int MIN_GREEN = 4;
  localparam int YELLOW    = 3;
  localparam int ALLRED    = 2;
  localparam int CNT_W     = 8;

  // Output vector layout: {NSG, NSY, NSR, EWG, EWY, EWR, fault, busy}
  localparam logic [7:0] AR  = 8'b00100101;
  localparam logic [7:0] NSG = 8'b10000100;
  localparam logic [7:0] NSY = 8'b01000101;
  localparam logic [7:0] EWG = 8'b00110000;
  localparam logic [7:0] EWY = 8'b00101001;
  localparam logic [7:0] FLT = 8'b00000010;

  logic clock = 1'b0;
  logic reset;
  logic NSLite;
  logic EWLite;
  logic NSGreen, NSYellow, NSRed, EWGreen, EWYellow, EWRed, fault, busy;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  lamp_sequencer #(
    .MIN_GREEN_CYCLES(MIN_GREEN),
    .YELLOW_CYCLES(YELLOW),
    .ALLRED_CYCLES(ALLRED),
    .CNT_W(CNT_W)
  ) dut (
    .clock(clock),
    .reset(reset),
    .NSLite(NSLite),
    .EWLite(EWLite),
    .NSGreen(NSGreen),
    .NSYellow(NSYellow),
    .NSRed(NSRed),
    .EWGreen(EWGreen),
    .EWYellow(EWYellow),
    .EWRed(EWRed),
    .fault(fault),
    .busy(busy)
  );

  // Reference model: which direction is served (or being cleared toward),
  // which stage of its cycle it is in, and how many cycles it has lasted.
  int mDir;       // 0 = north-south, 1 = east-west
  int mStage;     // 0 = green, 1 = yellow, 2 = all-red
  int mElapsed;
  bit mFault;
  bit mFlash;
  bit mFlashRed;
  bit mPrevBoth;
  int mFlashCount;

  function automatic void modelReset();
    mDir        = 0;
    mStage      = 2;
    mElapsed    = 0;
    mFault      = 1'b0;
    mFlash      = 1'b0;
    mFlashRed   = 1'b1;
    mPrevBoth   = 1'b0;
    mFlashCount = 0;
  endfunction

  function automatic void modelStep(bit ns, bit ew);
    bit wantOther;
    bit both;
    bit trip;
    mFault = (ns == ew);
    both = ns && ew;
    trip = both && mPrevBoth;
    mPrevBoth = both;
`ifdef LAMP_FAULT_FLASH_EN
    if (mFlash) begin
      mFlashCount++;
      if (mFlashCount == YELLOW) begin
        mFlashRed   = !mFlashRed;
        mFlashCount = 0;
      end
      return;
    end
    if (trip) begin
      mFlash      = 1'b1;
      mFlashRed   = 1'b1;
      mFlashCount = 0;
      return;
    end
`else
    if (trip) mFlash = 1'b0;
`endif
    wantOther = (mDir == 0) ? (ew && !ns) : (ns && !ew);
    case (mStage)
      0: begin
        if (wantOther && (mElapsed + 1 >= MIN_GREEN)) begin
          mStage = 1;
          mElapsed = 0;
        end else mElapsed++;
      end
      1: begin
        if (mElapsed + 1 == YELLOW) begin
          mStage = 2;
          mDir = 1 - mDir;
          mElapsed = 0;
        end else mElapsed++;
      end
      default: begin
        if (mElapsed + 1 == ALLRED) begin
          mStage = 0;
          mElapsed = 0;
        end else mElapsed++;
      end
    endcase
  endfunction

  function automatic logic [7:0] modelOut();
    bit nsG, nsY, ewG, ewY;
    if (mFlash) return {2'b00, mFlashRed, 2'b00, mFlashRed, mFault, 1'b1};
    nsG = (mStage == 0) && (mDir == 0);
    nsY = (mStage == 1) && (mDir == 0);
    ewG = (mStage == 0) && (mDir == 1);
    ewY = (mStage == 1) && (mDir == 1);
    return {nsG, nsY, !(nsG || nsY), ewG, ewY, !(ewG || ewY), mFault, mStage != 0};
  endfunction

  function automatic logic [7:0] dutOut();
    return {NSGreen, NSYellow, NSRed, EWGreen, EWYellow, EWRed, fault, busy};
  endfunction

  task automatic checkOutput(input string name, input logic [7:0] actual,
                             input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %b required %b (NSG NSY NSR EWG EWY EWR fault busy) at %0t",
               name, actual, expected, $time);
    end
  endtask

  // Drives one grant pair across one rising edge and steps the model with it;
  // returns 1 time unit after the edge, where outputs are sampled.
  task automatic applyStimulus(input bit ns, input bit ew);
    NSLite = ns;
    EWLite = ew;
    @(posedge clock);
    modelStep(ns, ew);
    #1;
  endtask

  task automatic runCycle(input bit ns, input bit ew, input string name);
    applyStimulus(ns, ew);
    checkOutput(name, dutOut(), modelOut());
  endtask

  task automatic doReset();
    reset  = 1'b1;
    NSLite = 1'b1;
    EWLite = 1'b0;
    #3;
    modelReset();
    checkOutput("resetState", dutOut(), AR);
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  // which: 0 waits for EWGreen, 1 waits for EWYellow
  task automatic runUntil(input bit ns, input bit ew, input int which, input string name);
    bit found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      runCycle(ns, ew, name);
      if ((which == 0 && EWGreen === 1'b1) || (which == 1 && EWYellow === 1'b1)) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: wait bound expired, lamp not reached (got 0 required 1)", name);
    end
  endtask

  typedef struct {
    logic       ns;
    logic       ew;
    logic [7:0] expected;
  } vector_t;

  vector_t vectors[24];

  initial begin
    watchdogStart();
  end

  task automatic watchdogStart();
    #3000000;
    $display("[TB] FAIL watchdog: simulation time limit reached (got timeout required finish)");
    $fatal(1, "[TB] watchdog");
  endtask

  initial begin
    int nsRun;
    int ewRun;
    bit curNs;
    int r;
    bit ns;
    bit ew;

    reset  = 1'b1;
    NSLite = 1'b0;
    EWLite = 1'b0;

    vectors[0]  = '{1'b1, 1'b0, AR};
    vectors[1]  = '{1'b1, 1'b0, NSG};
    vectors[2]  = '{1'b0, 1'b1, NSG};
    vectors[3]  = '{1'b0, 1'b1, NSG};
    vectors[4]  = '{1'b0, 1'b1, NSG};
    vectors[5]  = '{1'b0, 1'b1, NSY};
    vectors[6]  = '{1'b1, 1'b0, NSY};
    vectors[7]  = '{1'b1, 1'b0, NSY};
    vectors[8]  = '{1'b1, 1'b0, AR};
    vectors[9]  = '{1'b1, 1'b0, AR};
    vectors[10] = '{1'b1, 1'b0, EWG};
    vectors[11] = '{1'b1, 1'b0, EWG};
    vectors[12] = '{1'b1, 1'b0, EWG};
    vectors[13] = '{1'b1, 1'b0, EWG};
    vectors[14] = '{1'b1, 1'b0, EWY};
    vectors[15] = '{1'b1, 1'b0, EWY};
    vectors[16] = '{1'b1, 1'b0, EWY};
    vectors[17] = '{1'b1, 1'b0, AR};
    vectors[18] = '{1'b1, 1'b0, AR};
    vectors[19] = '{1'b1, 1'b0, NSG};
    vectors[20] = '{1'b1, 1'b1, NSG | FLT};
    vectors[21] = '{1'b1, 1'b0, NSG};
    vectors[22] = '{1'b0, 1'b0, NSG | FLT};
    vectors[23] = '{1'b1, 1'b0, NSG};

    #1;
    doReset();

    for (int i = 0; i < 24; i++) begin
      applyStimulus(vectors[i].ns, vectors[i].ew);
      checkOutput($sformatf("vector%0d", i), dutOut(), vectors[i].expected);
    end

    // Single-cycle illegal grant while EW is green: one-cycle fault, green held.
    runUntil(1'b0, 1'b1, 0, "toEwGreen");
    for (int i = 0; i < 4; i++) runCycle(1'b0, 1'b1, "ewHold");
    runCycle(1'b1, 1'b1, "bothHigh");
    checkOutput("faultPulse", dutOut(), EWG | FLT);
    runCycle(1'b0, 1'b1, "afterBoth");
    checkOutput("faultClear", dutOut(), EWG);

    // Asynchronous reset in the second cycle of EW yellow.
    runUntil(1'b1, 1'b0, 1, "toEwYellow");
    runCycle(1'b1, 1'b0, "ewYellow2");
    checkOutput("yellowSecond", dutOut(), EWY);
    #2;
    reset = 1'b1;
    #1;
    modelReset();
    checkOutput("resetMidYellow", dutOut(), AR);
    @(posedge clock);
    #1;
    reset = 1'b0;
    runCycle(1'b1, 1'b0, "restart1");
    checkOutput("restartAllRed", dutOut(), AR);
    runCycle(1'b1, 1'b0, "restart2");
    checkOutput("restartGreen", dutOut(), NSG);

`ifdef LAMP_FAULT_FLASH_EN
    runCycle(1'b1, 1'b1, "flashArm");
    runCycle(1'b1, 1'b1, "flashEnter");
    checkOutput("flashEntry", dutOut(), 8'b00100111);
    for (int i = 0; i < 3; i++) runCycle(1'b1, 1'b0, "flashRun");
    checkOutput("flashToggle", dutOut(), 8'b00000001);
    for (int i = 0; i < 9; i++) runCycle(1'b0, 1'b1, "flashSticky");
    #2;
`endif

    // Random grant traffic against the model, with safety and yellow-length checks.
    doReset();
    nsRun = 0;
    ewRun = 0;
    curNs = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      r = $urandom_range(0, 31);
      if (r < 3) curNs = !curNs;
      ns = curNs;
      ew = !curNs;
      if (r == 3) begin
        ns = 1'b0;
        ew = 1'b0;
      end
`ifndef LAMP_FAULT_FLASH_EN
      if (r == 4) begin
        ns = 1'b1;
        ew = 1'b1;
      end
`endif
      runCycle(ns, ew, "random");
      checks++;
      if ((NSGreen || NSYellow) && (EWGreen || EWYellow)) begin
        errors++;
        $display("[TB] FAIL exclusive: both directions active (got NS=%b%b EW=%b%b required one side 00)",
                 NSGreen, NSYellow, EWGreen, EWYellow);
      end
      if (NSYellow) nsRun++;
      else if (nsRun > 0) begin
        checks++;
        if (nsRun != YELLOW) begin
          errors++;
          $display("[TB] FAIL nsYellowLen: got %0d required %0d", nsRun, YELLOW);
        end
        nsRun = 0;
      end
      if (EWYellow) ewRun++;
      else if (ewRun > 0) begin
        checks++;
        if (ewRun != YELLOW) begin
          errors++;
          $display("[TB] FAIL ewYellowLen: got %0d required %0d", ewRun, YELLOW);
        end
        ewRun = 0;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
